ql_sync_fifo_ctrl: RTL

- Synchronous FIFO pointer/flag controller for one BRAM half when that half runs in FIFO mode with a common read/write clock.
- Sits directly downstream of the BRAM clock mux. It is clocked by the shared FIFO clock that the mux routes to both ports.
- Drives the BRAM write/read port enables and addresses, and produces occupancy flags.
- Data is not carried through this block: the BRAM data ports connect directly to the user. RAM read latency is 1 cycle.

---
 rtl/ql_sync_fifo_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/ql_sync_fifo_ctrl.sv
// rtl/ql_sync_fifo_ctrl.sv - synchronous FIFO pointer/flag controller for one BRAM half
module ql_sync_fifo_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK_i,
    input  logic              RESETN_i,
    input  logic              FMODE_i,
    input  logic              FLUSH_i,
    input  logic              PUSH_i,
    input  logic              POP_i,
    input  logic [ADDR_W-1:0] UPAE_i,
    input  logic [ADDR_W-1:0] UPAF_i,
    output logic              WEN_o,
    output logic [ADDR_W-1:0] WADDR_o,
    output logic              REN_o,
    output logic [ADDR_W-1:0] RADDR_o,
    output logic              RD_VALID_o,
    output logic [ADDR_W:0]   COUNT_o,
    output logic              EMPTY_o,
    output logic              FULL_o,
    output logic              ALMOST_EMPTY_o,
    output logic              ALMOST_FULL_o,
    output logic              OVERFLOW_o,
    output logic              UNDERFLOW_o
);

    // Full depth expressed in the (ADDR_W+1)-bit count domain.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // Pointers carry one extra bit so full and empty are distinguishable
    // and wrap naturally without any compare-and-reset logic.
    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] count;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic            almost_empty;
    logic            almost_full;
    logic            overflow;
    logic            underflow;

    logic            clr;
    logic            push_ok;
    logic            pop_ok;
    logic [ADDR_W:0] next_count;
    logic [ADDR_W:0] af_level;

    // Accept decisions use the registered flags; clear and reset mask both ports.
    always_comb begin
        clr        = FLUSH_i | ~FMODE_i;
        push_ok    = PUSH_i & ~full  & ~clr & RESETN_i;
        pop_ok     = POP_i  & ~empty & ~clr & RESETN_i;
        next_count = count + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop_ok};
        af_level   = DEPTH - {1'b0, UPAF_i};
    end

    // Pointer, occupancy, flag and sticky-error state; clear behaves like reset.
    always_ff @(posedge CLK_i) begin
        if (!RESETN_i || clr) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wptr         <= wptr + {{ADDR_W{1'b0}}, push_ok};
            rptr         <= rptr + {{ADDR_W{1'b0}}, pop_ok};
            count        <= next_count;
            rd_valid     <= pop_ok;
            empty        <= (next_count == '0);
            full         <= (next_count == DEPTH);
            almost_empty <= (next_count <= {1'b0, UPAE_i});
            almost_full  <= (next_count >= af_level);
            overflow     <= overflow  | (PUSH_i & full);
            underflow    <= underflow | (POP_i & empty);
        end
    end

    // Output wiring: enables are combinational, everything else registered.
    always_comb begin
        WEN_o          = push_ok;
        REN_o          = pop_ok;
        WADDR_o        = wptr[ADDR_W-1:0];
        RADDR_o        = rptr[ADDR_W-1:0];
        RD_VALID_o     = rd_valid;
        COUNT_o        = count;
        EMPTY_o        = empty;
        FULL_o         = full;
        ALMOST_EMPTY_o = almost_empty;
        ALMOST_FULL_o  = almost_full;
        OVERFLOW_o     = overflow;
        UNDERFLOW_o    = underflow;
    end

endmodule
